pwm_channel_bank: RTL and testbench

//   Multi-channel PWM generator; consumes per-channel (period, high-time, enable) configs from the PWM config parser.

---
 rtl/pwm_channel_bank.sv | 56 +++++
 tb/tb_pwm_channel_bank.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pwm_channel_bank.sv
// pwm_channel_bank: multi-channel PWM generator with period-boundary shadowed config updates
module pwm_channel_bank #(
  parameter int CH_NUM = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_config_vld,
  input  logic [7:0]        pwm_config_channel,
  input  logic              pwm_en,
  input  logic [27:0]       pwm_period,
  input  logic [27:0]       pwm_hlevel,
  output logic [CH_NUM-1:0] pwm_out,
  output logic [CH_NUM-1:0] pwm_pending,
  output logic              pwm_cfg_err
);
  logic in_range;
  assign in_range = {1'b0, pwm_config_channel} < 9'(CH_NUM);
  // one-cycle error pulse for configs aimed at a channel that does not exist
  always_ff @(posedge clk or posedge rst)
    if (rst) pwm_cfg_err <= 1'b0;
    else pwm_cfg_err <= pwm_config_vld && !in_range;
  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic a_en, s_en, pend, out, hit, run, bnd;
    logic [27:0] a_per, a_hl, s_per, s_hl, cnt;
    assign hit = pwm_config_vld && in_range && pwm_config_channel == 8'(i);
    assign run = a_en && a_per != 28'd0;
    assign bnd = run && cnt == a_per - 28'd1;
    // idle or boundary configs go straight to active; mid-period ones wait in the shadow
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        {a_en, a_per, a_hl} <= '0;
        {s_en, s_per, s_hl} <= '0;
        pend <= 1'b0;
        cnt <= '0;
        out <= 1'b0;
      end else begin
        out <= run && cnt < a_hl;
        if (hit && (!run || bnd)) begin
          {a_en, a_per, a_hl} <= {pwm_en, pwm_period, pwm_hlevel};
          pend <= 1'b0;
          cnt <= '0;
        end else begin
          if (hit) begin
            {s_en, s_per, s_hl} <= {pwm_en, pwm_period, pwm_hlevel};
            pend <= 1'b1;
          end else if (bnd && pend) begin
            {a_en, a_per, a_hl} <= {s_en, s_per, s_hl};
            pend <= 1'b0;
          end
          cnt <= run && !bnd ? cnt + 28'd1 : 28'd0;
        end
      end
    assign pwm_out[i] = out;
    assign pwm_pending[i] = pend;
  end
endmodule

// File: tb/tb_pwm_channel_bank.sv
// tb_pwm_channel_bank: cycle-keyed scoreboard bench for the PWM channel bank
module tb_pwm_channel_bank;
  localparam int N = 8;
  logic clk = 1'b0, rst = 1'b1, vld = 1'b0, en = 1'b0, done = 1'b0;
  logic [7:0] ch = '0;
  logic [27:0] per = '0, hl = '0;
  logic [N-1:0] pwm_out, pwm_pending;
  logic pwm_cfg_err;
  int cyc = 0, n_chk = 0, n_fail = 0;
  typedef struct {
    int c;
    int ch;
    logic o;
    logic p;
    logic ce;
    logic e;
    string nm;
  } chk_t;
  chk_t sb[$], rem[$];
  logic ao, ap;
  pwm_channel_bank #(.CH_NUM(N)) dut (
    .clk(clk),
    .rst(rst),
    .pwm_config_vld(vld),
    .pwm_config_channel(ch),
    .pwm_en(en),
    .pwm_period(per),
    .pwm_hlevel(hl),
    .pwm_out(pwm_out),
    .pwm_pending(pwm_pending),
    .pwm_cfg_err(pwm_cfg_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic cfg(input int c, input logic e, input int p, input int h);
    vld = 1'b1;
    ch = 8'(c);
    en = e;
    per = 28'(p);
    hl = 28'(h);
    @(posedge clk);
    #1;
    vld = 1'b0;
  endtask
  task automatic push(input int c, input int k, input logic o, input logic p, input logic ce, input logic e, input string nm);
    sb.push_back('{c, k, o, p, ce, e, nm});
  endtask
  // monitor: every cycle, compare the outputs against all expectations due now
  always @(negedge clk) begin
    rem = {};
    foreach (sb[k]) begin
      if (sb[k].c > cyc) rem.push_back(sb[k]);
      else begin
        n_chk++;
        ao = pwm_out[sb[k].ch[2:0]];
        ap = pwm_pending[sb[k].ch[2:0]];
        if (sb[k].c < cyc || ao !== sb[k].o || ap !== sb[k].p || (sb[k].ce && pwm_cfg_err !== sb[k].e)) begin
          n_fail++;
          $display("FAIL %s cyc=%0d ch=%0d out=%b want %b pend=%b want %b err=%b want %b",
                   sb[k].nm, sb[k].c, sb[k].ch, ao, sb[k].o, ap, sb[k].p, pwm_cfg_err, sb[k].ce ? sb[k].e : pwm_cfg_err);
        end
      end
    end
    sb = rem;
  end
  initial begin
    #5000;
    if (!done) begin
      n_fail++;
      $display("FAIL watchdog cyc=%0d did not reach end of stimulus", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end
  initial begin
    for (int c = 1; c <= 9; c++)
      for (int k = 0; k < N; k++) push(c, k, 1'b0, 1'b0, 1'b1, 1'b0, "reset_state");
    at(3);
    rst = 1'b0;
    at(10);
    for (int c = 11; c <= 31; c++) push(c, 0, c >= 12 && (c - 12) % 10 < 3, 1'b0, 1'b0, 1'b0, "t1_idle_10_3");
    cfg(0, 1'b1, 10, 3);
    at(32);
    for (int c = 32; c <= 50; c++)
      push(c, 0, c <= 34 ? 1'b1 : c <= 41 ? 1'b0 : (c - 42) % 4 < 2, c >= 34 && c <= 40, 1'b0, 1'b0, "t2_shadow_4_2");
    at(33);
    cfg(0, 1'b1, 4, 2);
    at(60);
    for (int c = 62; c <= 85; c++)
      push(c, 1, c <= 63 ? 1'b1 : c <= 71 ? 1'b0 : (c - 72) % 6 == 0, c >= 64 && c <= 70, 1'b0, 1'b0, "t3_last_write_wins");
    cfg(1, 1'b1, 10, 2);
    at(63);
    cfg(1, 1'b1, 8, 4);
    at(65);
    cfg(1, 1'b1, 6, 1);
    at(90);
    for (int c = 92; c <= 125; c++) push(c, 2, c <= 93 || c >= 102, 1'b0, 1'b0, 1'b0, "t4_boundary_bypass");
    cfg(2, 1'b1, 5, 2);
    at(95);
    cfg(2, 1'b1, 5, 0);
    at(100);
    cfg(2, 1'b1, 5, 10);
    at(118);
    for (int c = 118; c <= 155; c++)
      push(c, 0, c <= 145 && (c - 42) % 4 < 2, c >= 142 && c <= 144, c >= 119 && c <= 123, c == 121, "t5_err_disable_ch0");
    for (int c = 118; c <= 165; c++) begin
      push(c, 3, c >= 132, 1'b0, 1'b0, 1'b0, "t5_period1");
      for (int k = 4; k < N; k++) push(c, k, 1'b0, 1'b0, 1'b0, 1'b0, "t5_idle_or_period0");
    end
    at(120);
    cfg(8, 1'b1, 3, 1);
    at(130);
    cfg(3, 1'b1, 1, 1);
    cfg(4, 1'b1, 0, 5);
    at(141);
    cfg(0, 1'b0, 4, 2);
    at(158);
    for (int c = 160; c <= 190; c++)
      push(c, 0, (c >= 162 && c <= 164) || (c >= 184 && (c - 184) % 2 == 0), c == 164 || c == 165,
           c >= 166 && c <= 170, 1'b0, "t6_reset_midrun");
    for (int c = 166; c <= 180; c++)
      for (int k = 1; k < N; k++) push(c, k, 1'b0, 1'b0, 1'b0, 1'b0, "t6_reset_all");
    at(160);
    cfg(0, 1'b1, 10, 3);
    at(163);
    cfg(0, 1'b1, 4, 2);
    at(166);
    #2;
    rst = 1'b1;
    at(168);
    rst = 1'b0;
    at(182);
    cfg(0, 1'b1, 2, 1);
    at(195);
    done = 1'b1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expectations count=%0d want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
